// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B one bit per clock, LSB first, rippling borrow.
// Result and final borrow are registered and valid while done pulses (WIDTH+1 edges after start).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] DATAa,
    input  logic [WIDTH-1:0] DATAb,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic a_bit, b_bit, d_bit, bout;

    assign a_bit = sa_q[0];
    assign b_bit = sb_q[0];
    assign d_bit = a_bit ^ b_bit ^ bin_q;
    assign bout  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sa_d    = DATAa;
                    sb_d    = DATAb;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                bin_d  = bout;
                cnt_d  = cnt_q + CW'(1);
                // The final borrow is latched only on the last shift so it stays stable afterwards.
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    borrow_d = bout;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=4 and WIDTH=8 against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start4, start8;
    logic [3:0] a4, b4, diff4;
    logic [7:0] a8, b8, diff8;
    logic       borrow4, busy4, done4;
    logic       borrow8, busy8, done8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .DATAa(a4), .DATAb(b4),
        .diff(diff4), .borrow(borrow4), .busy(busy4), .done(done4)
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .DATAa(a8), .DATAb(b8),
        .diff(diff8), .borrow(borrow8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_diff(input int w, input int a, input int b);
        return 32'((a - b) & ((1 << w) - 1));
    endfunction

    function automatic logic model_borrow(input int a, input int b);
        return a < b;
    endfunction

    function automatic logic [31:0] get_diff(input int w);
        return (w == 4) ? 32'(diff4) : 32'(diff8);
    endfunction
    function automatic logic get_borrow(input int w);
        return (w == 4) ? borrow4 : borrow8;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic s, input int a, input int b);
        if (w == 4) begin
            start4 = s; a4 = 4'(a); b4 = 4'(b);
        end else begin
            start8 = s; a8 = 8'(a); b8 = 8'(b);
        end
    endtask

    // One operation with a single-cycle start. done is expected after the WIDTH-th edge
    // following the accepting edge E0 (E0..E_WIDTH is WIDTH+1 edges), busy for WIDTH+1 cycles.
    task automatic run_op(input int w, input int a, input int b, input string tag);
        int lat = 0;
        int busy_n;
        bit seen = 0;
        drive(w, 1'b1, a, b);
        tick();
        drive(w, 1'b0, (a + 5) & ((1 << w) - 1), (b + 3) & ((1 << w) - 1));
        busy_n = get_busy(w) ? 1 : 0;
        for (int i = 0; i < 3 * w; i++) begin
            tick();
            lat++;
            if (get_busy(w)) busy_n++;
            if (get_done(w)) begin
                seen = 1;
                break;
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(w));
        chk({tag, " diff"}, get_diff(w), model_diff(w, a, b));
        chk({tag, " borrow"}, 32'(get_borrow(w)), 32'(model_borrow(a, b)));
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(w + 1));
        tick();
        chk({tag, " done_pulse_len"}, 32'(get_done(w)), 32'd0);
        chk({tag, " busy_after"}, 32'(get_busy(w)), 32'd0);
        chk({tag, " diff_hold"}, get_diff(w), model_diff(w, a, b));
    endtask

    initial begin
        int t_done[$];
        logic [3:0] d_done[$];
        logic       b_done[$];
        int cyc;
        bit stray;

        reset = 1'b1;
        drive(4, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        tick();
        tick();
        chk("reset diff4", 32'(diff4), 32'd0);
        chk("reset borrow4", 32'(borrow4), 32'd0);
        chk("reset busy4", 32'(busy4), 32'd0);
        chk("reset done4", 32'(done4), 32'd0);
        chk("reset diff8", 32'(diff8), 32'd0);
        reset = 1'b0;
        tick();

        run_op(4, 9, 3, "basic 9-3");
        run_op(4, 3, 9, "neg 3-9");
        run_op(4, 0, 1, "neg 0-1");
        run_op(4, 0, 0, "zero 0-0");
        run_op(4, 15, 0, "max 15-0");

        // Second start mid-SHIFT with new operands, and toggling operands, must not disturb the result.
        drive(4, 1'b1, 9, 3);
        tick();
        chk("hold diff kept at load", 32'(diff4), 32'hF);
        drive(4, 1'b0, 4'hA, 4'h5);
        tick();
        drive(4, 1'b1, 1, 8);
        tick();
        drive(4, 1'b0, 4'h5, 4'hA);
        tick();
        drive(4, 1'b0, 4'hF, 4'hF);
        tick();
        chk("ign done", 32'(done4), 32'd1);
        chk("ign diff", 32'(diff4), 32'h6);
        chk("ign borrow", 32'(borrow4), 32'd0);
        tick();
        tick();
        chk("ign no restart", 32'(busy4), 32'd0);

        // Start held high: 9-3 then 15-15, operands swapped right after the first capture.
        drive(4, 1'b1, 9, 3);
        tick();
        drive(4, 1'b1, 15, 15);
        cyc = 0;
        while (t_done.size() < 2 && cyc < 40) begin
            tick();
            cyc++;
            if (done4) begin
                t_done.push_back(cyc);
                d_done.push_back(diff4);
                b_done.push_back(borrow4);
            end
        end
        drive(4, 1'b0, 0, 0);
        chk("b2b pulses", 32'(t_done.size()), 32'd2);
        if (t_done.size() == 2) begin
            chk("b2b spacing", 32'(t_done[1] - t_done[0]), 32'd6);
            chk("b2b diff0", 32'(d_done[0]), 32'h6);
            chk("b2b borrow0", 32'(b_done[0]), 32'd0);
            chk("b2b diff1", 32'(d_done[1]), 32'h0);
            chk("b2b borrow1", 32'(b_done[1]), 32'd0);
        end
        cyc = 0;
        while (busy4 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("b2b drain", 32'(busy4), 32'd0);
        tick();

        // Reset sampled on the second shift edge aborts the op with no done pulse.
        drive(4, 1'b1, 9, 3);
        tick();
        drive(4, 1'b0, 9, 3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst diff", 32'(diff4), 32'd0);
        chk("rst borrow", 32'(borrow4), 32'd0);
        chk("rst busy", 32'(busy4), 32'd0);
        chk("rst done", 32'(done4), 32'd0);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done4 || busy4) stray = 1;
        end
        chk("rst no done", 32'(stray), 32'd0);
        run_op(4, 7, 2, "post-rst 7-2");

        run_op(8, 200, 55, "w8 200-55");
        run_op(8, 55, 200, "w8 55-200");
        run_op(8, 255, 255, "w8 255-255");

        for (int n = 0; n < 25; n++) begin
            int ra = $urandom_range(0, 15);
            int rb = $urandom_range(0, 15);
            run_op(4, ra, rb, "rand4");
        end
        for (int n = 0; n < 25; n++) begin
            int ra = $urandom_range(0, 255);
            int rb = $urandom_range(0, 255);
            run_op(8, ra, rb, "rand8");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
